// File: rtl/shift_seq_pkg.sv
// Shared constants for the shift-sequence controller: shift_reg mode codes, FSM encoding, shift clamp.
// No logic of its own; imported by the controller and its counter.
package shift_seq_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [2:0] SHAMT_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  function automatic logic [2:0] clamp_shamt(input logic [2:0] s);
    return (s > SHAMT_MAX) ? SHAMT_MAX : s;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Controller <-> host/shift_reg bundle; slave is the controller side, master the environment side.
// Pure wiring, no latency, no backpressure.
interface shift_seq_ctrl_if;
  logic       start;
  logic [3:0] load_data;
  logic       dir;
  logic [2:0] shamt;
  logic       fill_bit;
  logic [3:0] p_out;
  logic       select1;
  logic       select0;
  logic [3:0] p_in;
  logic       right_shift_inp;
  logic       left_shift_inp;
  logic       busy;
  logic       done;

  modport slave (
    input  start, load_data, dir, shamt, fill_bit, p_out,
    output select1, select0, p_in, right_shift_inp, left_shift_inp, busy, done
  );

  modport master (
    output start, load_data, dir, shamt, fill_bit, p_out,
    input  select1, select0, p_in, right_shift_inp, left_shift_inp, busy, done
  );
endinterface

// File: rtl/shift_seq_cnt.sv
// 3-bit shift counter: load wins over decrement, decrement saturates at 0; 1-cycle update.
// No backpressure; load/dec are acted on every edge they are high.
module shift_seq_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic [2:0] cnt
);

  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load-and-shift sequencer for a 4-bit shift_reg; start-edge to done pulse is shamt+2 cycles (shamt clamped to 4).
// start is only sampled in IDLE (no queuing); SHIFT_SEQ_ROTATE_EN selects rotate instead of fill_bit.
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  shift_seq_ctrl_if.slave  bus
);

  state_e     state_q, state_d;
  logic [3:0] data_q, data_d;
  logic       dir_q, dir_d;
  logic       fill_q, fill_d;

  logic       accept;
  logic [2:0] cnt;
  logic [1:0] mode;
  logic       ser_bit;
  logic [3:0] p_in;
  logic       busy;
  logic       done;
  logic       rsi;
  logic       lsi;

  assign accept = (state_q == ST_IDLE) && bus.start;

  shift_seq_cnt u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (clamp_shamt(bus.shamt)),
    .dec      (state_q == ST_SHIFT),
    .cnt      (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      data_q  <= 4'd0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    fill_d  = fill_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_LOAD;
          data_d  = bus.load_data;
          dir_d   = bus.dir;
          fill_d  = bus.fill_bit;
        end
      end
      ST_LOAD:  state_d = (cnt != 3'd0) ? ST_SHIFT : ST_DONE;
      // cnt still holds the remaining count including this cycle's shift
      ST_SHIFT: state_d = (cnt <= 3'd1) ? ST_DONE : ST_SHIFT;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

`ifdef SHIFT_SEQ_ROTATE_EN
  logic unused_fill;
  assign unused_fill = fill_q;
  assign ser_bit     = dir_q ? bus.p_out[3] : bus.p_out[0];
`else
  logic unused_p_out;
  assign unused_p_out = ^bus.p_out;
  assign ser_bit      = fill_q;
`endif

  always_comb begin
    mode = MODE_HOLD;
    p_in = 4'd0;
    busy = 1'b0;
    done = 1'b0;
    rsi  = 1'b0;
    lsi  = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: begin
        mode = MODE_LOAD;
        p_in = data_q;
        busy = 1'b1;
      end
      ST_SHIFT: begin
        mode = dir_q ? MODE_SHL : MODE_SHR;
        busy = 1'b1;
        rsi  = !dir_q & ser_bit;
        lsi  = dir_q & ser_bit;
      end
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign bus.select1         = mode[1];
  assign bus.select0         = mode[0];
  assign bus.p_in            = p_in;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.right_shift_inp = rsi;
  assign bus.left_shift_inp  = lsi;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench: controller driving a behavioural 4-bit shift_reg; checks sequencing, data, reset abort.
// Expected values are hand-derived; rotate-mode expectations selected by SHIFT_SEQ_ROTATE_EN.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst_n;
  logic [3:0] sr_q;
  int checks;
  int failures;
  int lat;
  int bcnt;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shift_reg: 00 hold, 01 right (serial into bit 3), 10 left (serial into bit 0), 11 load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= 4'd0;
    end else begin
      case ({bus.select1, bus.select0})
        2'b11:   sr_q <= bus.p_in;
        2'b01:   sr_q <= {bus.right_shift_inp, sr_q[3:1]};
        2'b10:   sr_q <= {sr_q[2:0], bus.left_shift_inp};
        default: sr_q <= sr_q;
      endcase
    end
  end
  assign bus.p_out = sr_q;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {bus.select1, bus.select0, bus.busy, bus.done,
              bus.right_shift_inp, bus.left_shift_inp, 2'b00}, 8'h00);
    chk({tag, "_pin"}, {4'h0, bus.p_in}, 8'h00);
  endtask

  // Pulses start for one edge, then runs until done; lat = edges from start to done (-1 on timeout)
  task automatic run_seq(input logic [3:0] d, input logic dr, input logic [2:0] sa, input logic fb,
                         output int latency, output int busy_cycles);
    latency     = -1;
    busy_cycles = 0;
    bus.start     = 1'b1;
    bus.load_data = d;
    bus.dir       = dr;
    bus.shamt     = sa;
    bus.fill_bit  = fb;
    for (int i = 0; i < 20; i++) begin
      step();
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        latency = i + 1;
        break;
      end
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.load_data = 4'd0;
    bus.dir       = 1'b0;
    bus.shamt     = 3'd0;
    bus.fill_bit  = 1'b0;
    #2;
    chk_idle("reset_state");
    #10;
    rst_n = 1'b1;
    step();
    chk_idle("idle_no_start");

    // 1011 right by 2, fill 0; operands changed after acceptance
    bus.start = 1'b1; bus.load_data = 4'b1011; bus.dir = 1'b0; bus.shamt = 3'd2; bus.fill_bit = 1'b0;
    step();
    bus.start = 1'b0; bus.load_data = 4'b0000; bus.dir = 1'b1; bus.shamt = 3'd4; bus.fill_bit = 1'b1;
    chk("t1_load_sel", {6'd0, bus.select1, bus.select0}, 8'h03);
    chk("t1_load_pin", {4'h0, bus.p_in}, 8'h0b);
    chk("t1_load_busy", {7'd0, bus.busy}, 8'h01);
    step();
    chk("t1_shift1_sel", {6'd0, bus.select1, bus.select0}, 8'h01);
    chk("t1_shift1_pout", {4'h0, bus.p_out}, 8'h0b);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t1_shift1_rsi", {7'd0, bus.right_shift_inp}, 8'h01);
`else
    chk("t1_shift1_rsi", {7'd0, bus.right_shift_inp}, 8'h00);
`endif
    chk("t1_shift1_lsi", {7'd0, bus.left_shift_inp}, 8'h00);
    step();
    chk("t1_shift2_sel", {6'd0, bus.select1, bus.select0}, 8'h01);
    step();
    chk("t1_done", {6'd0, bus.busy, bus.done}, 8'h01);
    chk("t1_done_sel", {6'd0, bus.select1, bus.select0}, 8'h00);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t1_pout", {4'h0, bus.p_out}, 8'h0e);
`else
    chk("t1_pout", {4'h0, bus.p_out}, 8'h02);
`endif
    step();
    chk_idle("t1_back_idle");

    // 0011 left by 3, fill 1
    run_seq(4'b0011, 1'b1, 3'd3, 1'b1, lat, bcnt);
    chk("t2_latency", lat[7:0], 8'd5);
    chk("t2_busy_cycles", bcnt[7:0], 8'd4);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t2_pout", {4'h0, bus.p_out}, 8'h09);
`else
    chk("t2_pout", {4'h0, bus.p_out}, 8'h0f);
`endif
    step();

    // shamt 0: LOAD straight to DONE
    run_seq(4'b0110, 1'b0, 3'd0, 1'b1, lat, bcnt);
    chk("t3_latency", lat[7:0], 8'd2);
    chk("t3_busy_cycles", bcnt[7:0], 8'd1);
    chk("t3_pout", {4'h0, bus.p_out}, 8'h06);
    step();

    // shamt 7 clamps to 4 shifts
    run_seq(4'b0001, 1'b0, 3'd7, 1'b1, lat, bcnt);
    chk("t4_latency", lat[7:0], 8'd6);
    chk("t4_busy_cycles", bcnt[7:0], 8'd5);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t4_pout", {4'h0, bus.p_out}, 8'h01);
`else
    chk("t4_pout", {4'h0, bus.p_out}, 8'h0f);
`endif
    step();

    // 1001 right by 1, fill 0
    run_seq(4'b1001, 1'b0, 3'd1, 1'b0, lat, bcnt);
    chk("t5_latency", lat[7:0], 8'd3);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t5_pout", {4'h0, bus.p_out}, 8'h0c);
`else
    chk("t5_pout", {4'h0, bus.p_out}, 8'h04);
`endif
    step();

    // start re-pulsed during SHIFT is ignored
    bus.start = 1'b1; bus.load_data = 4'b1000; bus.dir = 1'b0; bus.shamt = 3'd2; bus.fill_bit = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    bus.start = 1'b1; bus.load_data = 4'b1111;
    step();
    bus.start = 1'b0;
    chk("t6_still_shift", {6'd0, bus.select1, bus.select0}, 8'h01);
    step();
    chk("t6_done", {6'd0, bus.busy, bus.done}, 8'h01);
    chk("t6_pout", {4'h0, bus.p_out}, 8'h02);
    step();
    step();
    chk_idle("t6_no_queue");

    // start held high: one IDLE cycle between sequences
    bus.start = 1'b1; bus.load_data = 4'b0101; bus.dir = 1'b0; bus.shamt = 3'd0;
    step();
    chk("t7_load1", {6'd0, bus.select1, bus.select0}, 8'h03);
    step();
    chk("t7_done1", {7'd0, bus.done}, 8'h01);
    step();
    chk("t7_idle_gap", {6'd0, bus.busy, bus.done}, 8'h00);
    step();
    bus.start = 1'b0;
    chk("t7_load2", {6'd0, bus.select1, bus.select0}, 8'h03);
    step();
    chk("t7_done2", {7'd0, bus.done}, 8'h01);
    step();

    // reset mid-SHIFT between edges
    bus.start = 1'b1; bus.load_data = 4'b1111; bus.dir = 1'b0; bus.shamt = 3'd4; bus.fill_bit = 1'b0;
    step();
    bus.start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("t8_async_clear");
    step();
    chk("t8_no_done_a", {7'd0, bus.done}, 8'h00);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t8_no_done", {6'd0, bus.busy, bus.done}, 8'h00);
    end
    run_seq(4'b0110, 1'b1, 3'd1, 1'b1, lat, bcnt);
    chk("t8_restart_latency", lat[7:0], 8'd3);
`ifdef SHIFT_SEQ_ROTATE_EN
    chk("t8_restart_pout", {4'h0, bus.p_out}, 8'h0c);
`else
    chk("t8_restart_pout", {4'h0, bus.p_out}, 8'h0d);
`endif
    step();
    chk_idle("t8_final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the only clock.
REQ-002 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: start  input  1  request a load-and-shift sequence; sampled only in IDLE.
REQ-004 SHALL have port: load_data  input  4  word to parallel-load into shift_reg.
REQ-005 SHALL have port: dir  input  1  0 = shift right, 1 = shift left.
REQ-006 SHALL have port: shamt  input  3  number of shift cycles; values >4 clamp to 4.
REQ-007 SHALL have port: fill_bit  input  1  serial bit fed into the vacated position.
REQ-008 SHALL have port: p_out  input  4  current shift_reg contents, used only for rotate.
REQ-009 SHALL have ports: select1, select0  output  1 each  shift_reg mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-010 SHALL have port: p_in  output  4  parallel-load word to shift_reg.
REQ-011 SHALL have ports: right_shift_inp, left_shift_inp  output  1 each  serial inputs to shift_reg.
REQ-012 SHALL have ports: busy  output  1  high in LOAD and SHIFT; done  output  1  one-cycle pulse in DONE.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE; all outputs decoded from registered state and latched operands only.
REQ-014 IDLE with start=1 at a clk edge SHALL latch load_data, dir, clamped shamt and fill_bit, then enter LOAD; start=0 SHALL keep IDLE.
REQ-015 LOAD SHALL last exactly one cycle with {select1,select0}=11 and p_in = latched data; next state SHIFT if shamt>0, else DONE.
REQ-016 SHIFT SHALL last exactly shamt cycles with {select1,select0}=01 (dir=0) or 10 (dir=1), tracked by a 3-bit down counter.
REQ-017 In a right shift, right_shift_inp SHALL carry the serial bit and enter bit 3; in a left shift, left_shift_inp SHALL carry it and enter bit 0; the inactive serial input SHALL be 0.
REQ-018 DONE SHALL last one cycle with {select1,select0}=00, done=1, busy=0, then return to IDLE.
REQ-019 start asserted in LOAD, SHIFT or DONE SHALL be ignored; no queuing. start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-020 Latency start-edge to done pulse SHALL be shamt+2 cycles; back-to-back sequences SHALL be separated by at least one IDLE cycle.
REQ-021 In IDLE, outputs SHALL be select=00, p_in=0, serial inputs 0, busy=0, done=0.
REQ-022 Changes on load_data, dir, shamt or fill_bit after acceptance SHALL not affect the running sequence.

Reset
REQ-023 rst_n low SHALL immediately, without waiting for clk, force state IDLE, counter 0, latched operands 0, and all outputs to REQ-021 values.
REQ-024 Reset asserted mid-LOAD or mid-SHIFT SHALL abort the sequence with no done pulse; operation resumes on the first clk edge after rst_n is released.

Configuration
REQ-025 With SHIFT_SEQ_ROTATE_EN defined, the serial bit SHALL be p_out[0] for right shifts and p_out[3] for left shifts (rotate), and fill_bit SHALL be ignored.
REQ-026 Without SHIFT_SEQ_ROTATE_EN, the serial bit SHALL be the latched fill_bit; the p_out port SHALL remain present and unused.

Structure
REQ-027 The package shift_seq_pkg SHALL hold the mode constants (MODE_HOLD, MODE_SHR, MODE_SHL, MODE_LOAD), the FSM state encoding, and SHAMT_MAX=4.
REQ-028 The 3-bit load/decrement shift counter SHALL be the one sub-module, shift_seq_cnt; the bench SHALL connect the block to the existing shift_reg.

Verification
REQ-029 Test: load_data=1011, dir=0, shamt=2, fill=0, start at cycle 0 -> LOAD cycle 1, SHIFT cycles 2-3, done at cycle 4, p_out=0010.
REQ-030 Test: load_data=0011, dir=1, shamt=3, fill=1 -> p_out=1111 at done, busy high for exactly 4 cycles.
REQ-031 Test: shamt=0, load_data=0110 -> LOAD then DONE, done 2 cycles after start, p_out=0110; shamt=7 -> exactly 4 shift cycles.
REQ-032 Test: start re-pulsed during SHIFT -> ignored; start held high continuously -> new LOAD on the first IDLE cycle after DONE.
REQ-033 Test: rst_n dropped mid-SHIFT between clk edges -> outputs clear immediately, no done pulse, clean restart afterwards.
REQ-034 Test: with SHIFT_SEQ_ROTATE_EN, load_data=1001, dir=0, shamt=1 -> p_out=1100; without the macro, fill=0 gives p_out=0100.
